ghash_core: RTL and testbench
=============================

# ghash_core

Sequential GHASH engine for AES-GCM, wrapping one instance of the combinational `gf128_multiplier`. It accumulates the 128-bit blocks of a message as Y_i = (Y_{i-1} xor X_i) • H and returns the final Y as the GHASH tag. Upstream, a block source (AAD/ciphertext/length-block packer) feeds it. Downstream, the GCM tag stage consumes the result and XORs it with E(K, J0).

## Interface

Parameters:
- `REG_MUL_IN`, default 1. 1 registers the multiplier x-operand, giving 2 cycles per block. 0 gives a direct accumulate, 1 block per cycle.

Ports:
- `clk` in 1. Single clock; all state updates on its rising edge.
- `rst` in 1. Reset, asynchronous and active-high.
- `h_in` in 128. Hash subkey H.
- `h_load` in 1. Loads `h_in` into the H register; honoured only in IDLE.
- `start` in 1. Clears Y to 0 and enters ACCEPT; honoured only in IDLE.
- `blk_data` in 128. Message block X_i, GCM bit order (bit 127 = coefficient of x^0).
- `blk_valid` in 1. Block present.
- `blk_last` in 1. Qualifies the final block (the caller's lengths block).
- `blk_ready` out 1. Block can be accepted this cycle.
- `tag_data` out 128. Final GHASH value.
- `tag_valid` out 1. `tag_data` is valid.
- `tag_ready` in 1. Consumer accepts the tag.
- `busy` out 1. High in any state other than IDLE.

## Operation

- States: IDLE, ACCEPT, MUL (present only when `REG_MUL_IN`=1), OUTPUT.
- Registers: H, Y and `last_q`. When `REG_MUL_IN`=1 there is also `xop`.
- Multiplier operands:
  - x = `xop` when `REG_MUL_IN`=1, otherwise Y xor `blk_data`.
  - y = H.
- IDLE:
  - `h_load`=1 → H <= `h_in`.
  - `start`=1 → Y <= 0, go to ACCEPT.
  - If both are high in the same cycle, both take effect; the first block uses the new H.
  - `blk_valid` is ignored and `blk_ready`=0.
- ACCEPT: `blk_ready`=1. A handshake is `blk_valid` && `blk_ready`.
  - `REG_MUL_IN`=1: on handshake, `xop` <= Y xor `blk_data` and `last_q` <= `blk_last`; go to MUL.
  - `REG_MUL_IN`=0: on handshake, Y <= z. If `blk_last`, go to OUTPUT; otherwise stay in ACCEPT.
- MUL: `blk_ready`=0; Y <= z. If `last_q`, go to OUTPUT; otherwise go to ACCEPT.
- OUTPUT:
  - `tag_valid`=1 and `tag_data`=Y, held stable until `tag_ready`.
  - On `tag_valid` && `tag_ready`, go to IDLE. Y is retained but no longer presented.
- `start` and `h_load` are ignored outside IDLE. H is never altered mid-message.
- No padding or length formatting is done here. The caller supplies zero-padded blocks and the len(A)||len(C) block as the last block.
- All arithmetic is GF(2^128) with the GCM polynomial, as implemented by `gf128_multiplier`. XOR is bitwise, 128 bits, with no carries.

## Timing

- Reset values:
  - state = IDLE.
  - H, Y, `xop` = 0; `last_q` = 0.
  - `blk_ready`=0, `tag_valid`=0, `tag_data`=0, `busy`=0.
- Reset asserted mid-operation aborts the message immediately. After release the block waits in IDLE with H cleared, so H must be reloaded.
- `tag_data` outside OUTPUT is driven to 0.
- Throughput:
  - `REG_MUL_IN`=1: one block per 2 cycles.
  - `REG_MUL_IN`=0: one block per cycle.
- Latency from the last-block handshake to `tag_valid`:
  - `REG_MUL_IN`=1: 2 cycles (edge t: `xop`; edge t+1: Y; `tag_valid` is high from t+1).
  - `REG_MUL_IN`=0: 1 cycle.
- Single-block message: `start` then one block with `blk_last`=1 is legal.
- `blk_valid` may be held high while `blk_ready`=0. Data must stay stable until accepted.
- `tag_ready` may be high before `tag_valid`. The tag is then consumed on its first valid cycle, and IDLE is reached the next cycle.
- `busy` is combinational from state.

## Test plan

- Two-block GCM vector. Stimulus: H=66e94bd4ef8a2c3b884cfa59ca342b2e; blocks 0388dace60b6a392f328c2b971b2fe78, then 00000000000000000000000000000080 with `blk_last`=1.
  - Required: intermediate Y = 5e2ec746917062882c85b0685353deb7; tag f38cbb1ad69223dcc3457ae5b6b0f885.
  - Run with both `REG_MUL_IN` settings.
- Single block. Stimulus: H=b83b533708bf535d0aa6e52980d53b78; one block ba471e049da20e40495e28e58ca8c555 with `blk_last`.
  - Required: tag b714c9048389afd9f9bc5c1d4378e052; latency 2 cycles when `REG_MUL_IN`=1.
- Backpressure. Stimulus: hold `tag_ready`=0 for 5 cycles, and toggle `blk_valid` randomly during the first vector.
  - Required: `tag_data` stable and `tag_valid` held for all 5 cycles; tag value unchanged; `blk_ready`=0 in MUL.
- Control ignored while busy. Stimulus: pulse `h_load` (`h_in`=all-ones) and `start` mid-message during the first vector.
  - Required: both are ignored and the tag is still f38cbb1a…f885.
- Reset mid-message. Stimulus: assert `rst` after the first block.
  - Required: `blk_ready`=0, `busy`=0, `tag_valid`=0 immediately. After reload of H and a rerun, the correct tag is produced.
- Back-to-back messages. Stimulus: raise `start` in the cycle after the tag handshake.
  - Required: Y is cleared and the second message's tag is correct, with no carry-over from the first message.

Source files
------------

// File: rtl/ghash_core.sv
// GHASH engine for AES-GCM: accumulates Y_i = (Y_{i-1} ^ X_i) * H over a message
// and presents the final Y as the tag. Includes the bit-serial-unrolled GF(2^128) multiplier.

module gf128_multiplier (
    input  logic [127:0] x,
    input  logic [127:0] y,
    output logic [127:0] z
);
    // Reduction constant for x^128 + x^7 + x^2 + x + 1 in reflected (GCM) bit order.
    localparam logic [127:0] R = {8'he1, 120'h0};

    logic [127:0] v;

    always_comb begin
        z = '0;
        v = y;
        for (int i = 0; i < 128; i++) begin
            if (x[127-i]) begin
                z = z ^ v;
            end
            v = v[0] ? ((v >> 1) ^ R) : (v >> 1);
        end
    end
endmodule

// state  | meaning
// IDLE   | waiting for start; H may be loaded
// ACCEPT | ready for the next message block
// MUL    | registered x-operand being multiplied (REG_MUL_IN=1 only)
// OUTPUT | tag presented until tag_ready
module ghash_core #(
    parameter int REG_MUL_IN = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [127:0] h_in,
    input  logic         h_load,
    input  logic         start,
    input  logic [127:0] blk_data,
    input  logic         blk_valid,
    input  logic         blk_last,
    output logic         blk_ready,
    output logic [127:0] tag_data,
    output logic         tag_valid,
    input  logic         tag_ready,
    output logic         busy
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCEPT = 2'd1,
        MUL    = 2'd2,
        OUTPUT = 2'd3
    } state_t;

    state_t       state, state_nxt;
    logic [127:0] h_q, y_q, xop_q;
    logic         last_q;
    logic [127:0] mul_x, mul_z;
    logic         h_we, y_clr, y_we, xop_we;

    assign mul_x = (REG_MUL_IN != 0) ? xop_q : (y_q ^ blk_data);

    gf128_multiplier u_mul (
        .x (mul_x),
        .y (h_q),
        .z (mul_z)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            h_q    <= '0;
            y_q    <= '0;
            xop_q  <= '0;
            last_q <= 1'b0;
        end else begin
            state <= state_nxt;
            if (h_we) begin
                h_q <= h_in;
            end
            if (y_clr) begin
                y_q <= '0;
            end else if (y_we) begin
                y_q <= mul_z;
            end
            if (xop_we) begin
                xop_q  <= y_q ^ blk_data;
                last_q <= blk_last;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        blk_ready = 1'b0;
        tag_valid = 1'b0;
        h_we      = 1'b0;
        y_clr     = 1'b0;
        y_we      = 1'b0;
        xop_we    = 1'b0;
        case (state)
            IDLE: begin
                h_we = h_load;
                if (start) begin
                    y_clr     = 1'b1;
                    state_nxt = ACCEPT;
                end
            end
            ACCEPT: begin
                blk_ready = 1'b1;
                if (blk_valid) begin
                    if (REG_MUL_IN != 0) begin
                        xop_we    = 1'b1;
                        state_nxt = MUL;
                    end else begin
                        y_we = 1'b1;
                        if (blk_last) begin
                            state_nxt = OUTPUT;
                        end
                    end
                end
            end
            MUL: begin
                y_we      = 1'b1;
                state_nxt = last_q ? OUTPUT : ACCEPT;
            end
            OUTPUT: begin
                tag_valid = 1'b1;
                if (tag_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy     = (state != IDLE);
    assign tag_data = tag_valid ? y_q : '0;
endmodule

// File: tb/tb_ghash_core.sv
// Directed bench for ghash_core: one instance with the registered multiplier operand,
// one with direct accumulate, both checked against hand-supplied GCM vectors.

module tb_ghash_core;
    localparam logic [127:0] H1   = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
    localparam logic [127:0] X1A  = 128'h0388dace60b6a392f328c2b971b2fe78;
    localparam logic [127:0] X1B  = 128'h00000000000000000000000000000080;
    localparam logic [127:0] Y1A  = 128'h5e2ec746917062882c85b0685353deb7;
    localparam logic [127:0] TAG1 = 128'hf38cbb1ad69223dcc3457ae5b6b0f885;
    localparam logic [127:0] H2   = 128'hb83b533708bf535d0aa6e52980d53b78;
    localparam logic [127:0] X2   = 128'hba471e049da20e40495e28e58ca8c555;
    localparam logic [127:0] TAG2 = 128'hb714c9048389afd9f9bc5c1d4378e052;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic [127:0] a_h_in = '0, a_blk_data = '0, a_tag_data;
    logic a_h_load = 0, a_start = 0, a_blk_valid = 0, a_blk_last = 0, a_tag_ready = 0;
    logic a_blk_ready, a_tag_valid, a_busy;

    logic [127:0] b_h_in = '0, b_blk_data = '0, b_tag_data;
    logic b_h_load = 0, b_start = 0, b_blk_valid = 0, b_blk_last = 0, b_tag_ready = 0;
    logic b_blk_ready, b_tag_valid, b_busy;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ghash_core #(.REG_MUL_IN(1)) u_dut_reg (
        .clk(clk), .rst(rst), .h_in(a_h_in), .h_load(a_h_load), .start(a_start),
        .blk_data(a_blk_data), .blk_valid(a_blk_valid), .blk_last(a_blk_last),
        .blk_ready(a_blk_ready), .tag_data(a_tag_data), .tag_valid(a_tag_valid),
        .tag_ready(a_tag_ready), .busy(a_busy)
    );

    ghash_core #(.REG_MUL_IN(0)) u_dut_dir (
        .clk(clk), .rst(rst), .h_in(b_h_in), .h_load(b_h_load), .start(b_start),
        .blk_data(b_blk_data), .blk_valid(b_blk_valid), .blk_last(b_blk_last),
        .blk_ready(b_blk_ready), .tag_data(b_tag_data), .tag_valid(b_tag_valid),
        .tag_ready(b_tag_ready), .busy(b_busy)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Returns after the handshake edge; jitter randomly drops blk_valid while waiting.
    task automatic a_send(input logic [127:0] d, input logic l, input bit jitter);
        int n;
        bit done;
        n = 0;
        done = 0;
        a_blk_data = d;
        a_blk_last = l;
        while (!done) begin
            a_blk_valid = jitter ? 1'($urandom_range(0, 1)) : 1'b1;
            if (a_blk_valid && a_blk_ready) begin
                done = 1;
            end else if (n > 50) begin
                chk("a_send_timeout", 1'b0, 1'b1);
                done = 1;
            end
            step();
            n++;
        end
        a_blk_valid = 1'b0;
        a_blk_last  = 1'b0;
    endtask

    task automatic a_wait_tag(input logic [127:0] exp_tag, input int exp_lat, input string tag);
        int lat;
        lat = 1;
        while (!a_tag_valid && lat < 20) begin
            step();
            lat++;
        end
        chk({tag, "_valid"}, a_tag_valid, 1'b1);
        chk({tag, "_lat"}, 128'(lat), 128'(exp_lat));
        chk({tag, "_tag"}, a_tag_data, exp_tag);
    endtask

    task automatic a_take_tag();
        a_tag_ready = 1'b1;
        step();
        a_tag_ready = 1'b0;
        chk("a_idle_after_tag", a_busy, 1'b0);
    endtask

    task automatic a_begin(input logic [127:0] h, input bit load);
        a_h_in   = h;
        a_h_load = load;
        a_start  = 1'b1;
        step();
        a_h_load = 1'b0;
        a_start  = 1'b0;
    endtask

    initial begin
        step();
        step();
        chk("rst_blk_ready", a_blk_ready, 1'b0);
        chk("rst_tag_valid", a_tag_valid, 1'b0);
        chk("rst_tag_data", a_tag_data, '0);
        chk("rst_busy", a_busy, 1'b0);
        rst = 1'b0;
        step();

        // Two-block vector with jittered valid, mid-message control pulses and tag backpressure.
        a_begin(H1, 1'b1);
        chk("a_busy_accept", a_busy, 1'b1);
        a_send(X1A, 1'b0, 1'b1);
        chk("a_ready_in_mul", a_blk_ready, 1'b0);
        a_h_in   = '1;
        a_h_load = 1'b1;
        a_start  = 1'b1;
        step();
        step();
        a_h_load = 1'b0;
        a_start  = 1'b0;
        a_send(X1B, 1'b1, 1'b1);
        a_wait_tag(TAG1, 2, "a_two_blk");
        for (int i = 0; i < 5; i++) begin
            step();
            chk("a_bp_valid", a_tag_valid, 1'b1);
            chk("a_bp_data", a_tag_data, TAG1);
        end
        a_take_tag();
        chk("a_tag_data_idle", a_tag_data, '0);

        // Back-to-back: start right after the handshake, H retained.
        a_begin('0, 1'b0);
        a_send(X1A, 1'b1, 1'b0);
        a_wait_tag(Y1A, 2, "a_b2b");
        a_take_tag();

        a_begin(H2, 1'b1);
        a_send(X2, 1'b1, 1'b0);
        a_wait_tag(TAG2, 2, "a_single");
        a_take_tag();

        // Reset after the first block aborts at once and clears H.
        a_begin(H1, 1'b1);
        a_send(X1A, 1'b0, 1'b0);
        rst = 1'b1;
        #1;
        chk("mid_rst_blk_ready", a_blk_ready, 1'b0);
        chk("mid_rst_busy", a_busy, 1'b0);
        chk("mid_rst_tag_valid", a_tag_valid, 1'b0);
        step();
        rst = 1'b0;
        step();
        a_begin('0, 1'b0);
        a_send(X1A, 1'b1, 1'b0);
        a_wait_tag('0, 2, "a_h_cleared");
        a_take_tag();
        a_begin(H1, 1'b1);
        a_send(X1A, 1'b0, 1'b0);
        a_send(X1B, 1'b1, 1'b0);
        a_wait_tag(TAG1, 2, "a_rerun");
        a_take_tag();

        // Direct accumulate: one block per cycle, tag one cycle after the last handshake.
        b_h_in   = H1;
        b_h_load = 1'b1;
        b_start  = 1'b1;
        step();
        b_h_load    = 1'b0;
        b_start     = 1'b0;
        b_tag_ready = 1'b1;
        b_blk_valid = 1'b1;
        b_blk_data  = X1A;
        chk("b_ready0", b_blk_ready, 1'b1);
        step();
        chk("b_ready1", b_blk_ready, 1'b1);
        chk("b_no_tag_yet", b_tag_valid, 1'b0);
        b_blk_data = X1B;
        b_blk_last = 1'b1;
        step();
        b_blk_valid = 1'b0;
        b_blk_last  = 1'b0;
        chk("b_two_blk_valid", b_tag_valid, 1'b1);
        chk("b_two_blk_tag", b_tag_data, TAG1);
        step();
        chk("b_early_ready_idle", b_busy, 1'b0);
        b_tag_ready = 1'b0;

        b_h_in   = H2;
        b_h_load = 1'b1;
        b_start  = 1'b1;
        step();
        b_h_load    = 1'b0;
        b_start     = 1'b0;
        b_blk_valid = 1'b1;
        b_blk_data  = X2;
        b_blk_last  = 1'b1;
        step();
        b_blk_valid = 1'b0;
        b_blk_last  = 1'b0;
        chk("b_single_valid", b_tag_valid, 1'b1);
        chk("b_single_tag", b_tag_data, TAG2);
        b_tag_ready = 1'b1;
        step();
        b_tag_ready = 1'b0;
        chk("b_single_idle", b_busy, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
